// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N valid/ready demultiplexer with one holding slot per channel.
// Optional packet lock is enabled by defining STREAM_DEMUX_PKT_LOCK_EN.
module stream_demux #(
    parameter int WIDTH = 8,
    parameter int N     = 3,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]    in_sel,
    input  logic               in_last,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_last,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [7:0]         drop_cnt
);
    logic [N-1:0]       full_q;
    logic [N-1:0]       full_d;
    logic [N*WIDTH-1:0] data_q;
    logic [N*WIDTH-1:0] data_d;
    logic [N-1:0]       last_q;
    logic [N-1:0]       last_d;
    logic [7:0]         drop_q;
    logic [7:0]         drop_d;
    logic [SELW-1:0]    dst_s;
    logic [N-1:0]       dst_oh_s;
    logic               dst_ok_s;
    logic               accept_s;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
    typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_e;
    state_e          state_q;
    state_e          state_d;
    logic [SELW-1:0] lock_sel_q;
    logic [SELW-1:0] lock_sel_d;

    // Mid-packet, the captured select overrides in_sel
    always_comb begin
        if (state_q == LOCKED) begin
            dst_s = lock_sel_q;
        end else begin
            dst_s = in_sel;
        end
    end

    // Lock FSM next state
    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        case (state_q)
            IDLE: begin
                if (accept_s && !in_last) begin
                    state_d    = LOCKED;
                    lock_sel_d = in_sel;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (accept_s && in_last) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lock FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_sel_q <= {SELW{1'b0}};
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
        end
    end
`else
    // Without the lock every beat routes by its own select
    always_comb begin
        dst_s = in_sel;
    end
`endif

    // Decode destination; selects at or beyond N decode to all-zero (drop)
    always_comb begin
        dst_oh_s = {N{1'b0}};
        for (int k = 0; k < N; k++) begin
            if (32'(dst_s) == 32'(k)) begin
                dst_oh_s[k] = 1'b1;
            end else begin
                dst_oh_s[k] = 1'b0;
            end
        end
        dst_ok_s = |dst_oh_s;
        if (dst_ok_s) begin
            in_ready = |(dst_oh_s & (~full_q | out_ready));
        end else begin
            in_ready = 1'b1;
        end
    end

    assign accept_s = in_valid && in_ready;

    // Slot load/drain and saturating drop counter
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        last_d = last_q;
        drop_d = drop_q;
        for (int k = 0; k < N; k++) begin
            if (accept_s && dst_oh_s[k]) begin
                full_d[k]                 = 1'b1;
                data_d[k*WIDTH +: WIDTH]  = in_data;
                last_d[k]                 = in_last;
            end else if (out_ready[k]) begin
                full_d[k] = 1'b0;
            end else begin
                full_d[k] = full_q[k];
            end
        end
        if (accept_s && !dst_ok_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Slot and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= {N{1'b0}};
            data_q <= {(N*WIDTH){1'b0}};
            last_q <= {N{1'b0}};
            drop_q <= 8'd0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            last_q <= last_d;
            drop_q <= drop_d;
        end
    end

    assign out_valid = full_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign drop_cnt  = drop_q;

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-N stream demultiplexer with valid/ready handshaking. It is the routing counterpart of the 2:1 selector: one upstream stream is steered, beat by beat, to one of N downstream channels chosen by a per-beat select. Each output channel has a one-entry holding register, so a stalled channel never corrupts another channel's data. Beats addressed to a channel that does not exist are consumed, dropped and counted.

## Interface
- `WIDTH`, default 8: data width in bits.
- `N`, default 3: number of output channels. Legal range is 2 ≤ N ≤ 2^SELW.
- `SELW`, default 2: width of the select input in bits.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `in_data`  in  WIDTH: input beat payload.
- `in_sel`  in  SELW: destination channel index for the beat.
- `in_last`  in  1: marks the final beat of a packet.
- `in_valid`  in  1: input beat is present.
- `in_ready`  out  1: the block can accept the beat this cycle.
- `out_data`  out  N*WIDTH: channel k data occupies bits [k*WIDTH +: WIDTH].
- `out_last`  out  N: per-channel last flag.
- `out_valid`  out  N: per-channel valid.
- `out_ready`  in  N: per-channel ready from downstream.
- `drop_cnt`  out  8: count of dropped beats; saturates at 255.

## Operation
- **Destination:** `dst` is `in_sel`. When `STREAM_DEMUX_PKT_LOCK_EN` is defined and the block is LOCKED, `dst` is the locked select instead.
- **Per-channel slot:** channel k holds a `full[k]` flag plus data and last registers. `out_valid[k] = full[k]`, and the data and last outputs are driven directly from the slot registers.
- **Input ready:**
  - If `dst` < N: `in_ready = !full[dst] || out_ready[dst]`.
  - If `dst` ≥ N: `in_ready = 1`.
- **Acceptance:** a beat is accepted on a cycle where `in_valid && in_ready`.
- **Accepted beat with `dst` < N:** the slot for `dst` loads data and last, and `full[dst]` is 1 on the next cycle.
- **Accepted beat with `dst` ≥ N:** the beat is discarded. `drop_cnt` increments by 1 and saturates at 255 with no wrap.
- **Channel drain:** if `full[k] && out_ready[k]` and channel k is not loaded in the same cycle, `full[k]` clears to 0.
- **Simultaneous load and drain on the same channel:** the slot reloads and `full` stays 1. Each channel sustains one beat per cycle.
- **Channel independence:** channels drain independently. Backpressure on channel k only stalls beats addressed to k.
- **Reset values:** `full` = 0 for all channels, so `out_valid` = 0. `out_data` = 0, `out_last` = 0, `drop_cnt` = 0, FSM in IDLE.
- **Reset mid-operation:** in-flight slot contents are lost, no partial state survives, and any lock is released.

## Timing
- Latency is one cycle: a beat accepted at edge t appears on `out_valid`/`out_data` after edge t.
- `in_ready` is combinational from `in_sel`, the lock state, `full` and `out_ready`. There is no combinational path from `in_valid` to `in_ready`.
- `drop_cnt` updates on the edge at which the dropped beat is accepted.
- Upstream must hold `in_data`, `in_sel` and `in_last` stable while `in_valid && !in_ready`.

## Configuration
- Macro: `STREAM_DEMUX_PKT_LOCK_EN`.
- **Defined:** packet-lock FSM with states IDLE and LOCKED.
  - IDLE to LOCKED: an accepted beat with `in_last` = 0. `in_sel` at that beat is captured as the locked select.
  - LOCKED: `in_sel` is ignored, and all beats route to the locked select. This includes a locked out-of-range select, in which case the whole packet is dropped and each beat is counted.
  - LOCKED to IDLE: an accepted beat with `in_last` = 1.
  - A beat accepted in IDLE with `in_last` = 1 is a single-beat packet and does not enter LOCKED.
- **Undefined:** no FSM and no lock state; `in_sel` is honoured on every beat. `in_last` is still carried to `out_last` unchanged.

## Test plan
- **Basic routing:** after reset, all outputs are 0. Send 0x11 with sel = 0, 0x22 with sel = 1, 0x33 with sel = 2, all `out_ready` = 1. Each appears on its own channel one cycle after acceptance, `drop_cnt` = 0.
- **Backpressure:** `out_ready[1]` = 0. Send 0xA1 then 0xA2, both with sel = 1. The first is accepted and `in_ready` drops to 0 while channel 1 is full. Raising `out_ready[1]` delivers 0xA1 then 0xA2 back to back. A sel = 0 beat sent during the stall passes through unaffected.
- **Drop counter:** send 3 beats with sel = 3. `in_ready` = 1 throughout, no `out_valid` asserts, `drop_cnt` = 3. Send 300 such beats; `drop_cnt` holds at 255.
- **Packet lock (macro defined):** a 3-beat packet starts with sel = 2 and `in_last` = 0, and `in_sel` changes to 0 on beats 2 and 3. All three beats exit channel 2, and `out_last[2]` = 1 only on beat 3. The next beat with sel = 0 goes to channel 0.
- **Packet lock (macro undefined):** the same stimulus sends beats 2 and 3 to channel 0.
- **Async reset:** assert `rst` mid-packet with channel 1 full. `out_valid` goes to 0 immediately without a clock edge, the lock is cleared, and `drop_cnt` = 0. The first beat after release routes by its own `in_sel`.
